// File: rtl/rc_pkt_pkg.sv
// Shared types and constants for the USB receive packet decoder.
package rc_pkt_pkg;

  localparam logic PROCESSING = 1'b0;
  localparam logic RECEIVED   = 1'b1;

  typedef enum logic [1:0] {
    HSHAKE  = 2'd0,
    TOKEN   = 2'd1,
    DATA    = 2'd2,
    INVALID = 2'd3
  } pid_class_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } dec_state_t;

  // PID bytes as they appear after MSB-first capture
  localparam logic [7:0] PID_OUT   = 8'b10000111;
  localparam logic [7:0] PID_IN    = 8'b10010110;
  localparam logic [7:0] PID_SETUP = 8'b10110100;
  localparam logic [7:0] PID_DATA0 = 8'b11000011;
  localparam logic [7:0] PID_DATA1 = 8'b11010010;
  localparam logic [7:0] PID_ACK   = 8'b01001011;
  localparam logic [7:0] PID_NAK   = 8'b01011010;
  localparam logic [7:0] PID_STALL = 8'b01111000;

  localparam logic [4:0]  CRC5_POLY   = 5'b00101;
  localparam logic [4:0]  CRC5_INIT   = 5'b11111;
  localparam logic [4:0]  CRC5_RESID  = 5'b01100;
  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESID = 16'h800D;

  function automatic pid_class_t pid_class(input logic [7:0] pid);
    pid_class_t c;
    c = INVALID;
    if (pid[7:4] == ~pid[3:0]) begin
      case (pid)
        PID_OUT, PID_IN, PID_SETUP: c = TOKEN;
        PID_DATA0, PID_DATA1:       c = DATA;
        PID_ACK, PID_NAK, PID_STALL: c = HSHAKE;
        default:                    c = INVALID;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/rc_crc_lfsr.sv
// Serial MSB-first CRC shift register; i_init reloads the seed, i_en advances one bit.
module rc_crc_lfsr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = '0,
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_init,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_crc
);

  logic [WIDTH-1:0] r_crc;
  logic             w_fb;

  assign w_fb  = r_crc[WIDTH-1] ^ i_bit;
  assign o_crc = r_crc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_crc <= '0;
    end else if (i_init) begin
      r_crc <= INIT;
    end else if (i_en) begin
      r_crc <= {r_crc[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/rc_pkt_decoder.sv
// USB receive packet decoder: PID validation, class-selected CRC5/CRC16 check and
// variable-length payload capture, holding results until pkt_rec.
module rc_pkt_decoder
  import rc_pkt_pkg::*;
#(
  parameter int MAX_BYTES = 8,
  parameter int CNT_W     = $clog2(MAX_BYTES*8+25)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_decode,
  input  logic                   end_decode,
  input  logic                   s_in,
  input  logic                   pkt_rec,
  output logic                   pkt_status,
  output logic [7:0]             rc_pid,
  output pid_class_t             rc_class,
  output logic [MAX_BYTES*8-1:0] rc_data,
  output logic [CNT_W-1:0]       rc_nbytes,
  output logic [6:0]             rc_addr,
  output logic [3:0]             rc_endp,
  output logic                   PID_error,
  output logic                   CRC_error,
  output logic                   len_error
);

  localparam int               PAY_W   = MAX_BYTES*8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  dec_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_pid;
  logic [15:0]       r_dly;
  logic [PAY_W-1:0]  r_data;
  logic              w_begin, w_sample, w_crc_en, w_pay_en;
  logic [4:0]        w_crc5;
  logic [15:0]       w_crc16;

  logic [CNT_W-1:0]  w_len;
  logic              w_short, w_len_ok, w_crc_bad;
  pid_class_t        w_cls;

  logic              r_status;
  logic [7:0]        r_rc_pid;
  pid_class_t        r_rc_class;
  logic [PAY_W-1:0]  r_rc_data;
  logic [CNT_W-1:0]  r_rc_nbytes;
  logic [6:0]        r_rc_addr;
  logic [3:0]        r_rc_endp;
  logic              r_pid_err, r_crc_err, r_len_err;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_decode) w_state_nxt = end_decode ? S_CHECK : S_RECV;
      S_RECV:  if (end_decode)   w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = S_DONE;
      S_DONE:  if (pkt_rec)      w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_begin  = (r_state == S_IDLE) && start_decode;
  assign w_sample = (r_state == S_RECV) && !end_decode;
  assign w_crc_en = w_sample && (r_cnt >= CNT_W'(8));
  // Payload taps the delay-line output only once 16 post-PID bits are queued
  assign w_pay_en = w_sample && (r_cnt >= CNT_W'(24)) && (r_cnt < CNT_W'(PAY_W+24));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_pid  <= '0;
      r_dly  <= '0;
      r_data <= '0;
    end else if (w_begin) begin
      r_cnt  <= end_decode ? '0 : CNT_W'(1);
      r_pid  <= {7'b0, s_in & ~end_decode};
      r_dly  <= '0;
      r_data <= '0;
    end else if (w_sample) begin
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt < CNT_W'(8)) r_pid <= {r_pid[6:0], s_in};
      else                   r_dly <= {r_dly[14:0], s_in};
      if (w_pay_en) r_data <= {r_data[PAY_W-2:0], r_dly[15]};
    end
  end

  rc_crc_lfsr #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_init (r_state == S_IDLE),
    .i_en   (w_crc_en),
    .i_bit  (s_in),
    .o_crc  (w_crc5)
  );

  rc_crc_lfsr #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_init (r_state == S_IDLE),
    .i_en   (w_crc_en),
    .i_bit  (s_in),
    .o_crc  (w_crc16)
  );

  always_comb begin
    w_len     = r_cnt - CNT_W'(8);
    w_short   = (r_cnt < CNT_W'(8));
    w_cls     = w_short ? INVALID : pid_class(r_pid);
    w_len_ok  = !w_short;
    w_crc_bad = 1'b0;
    case (w_cls)
      HSHAKE: w_len_ok = (w_len == '0);
      TOKEN: begin
        w_len_ok  = (w_len == CNT_W'(16));
        w_crc_bad = (w_crc5 != CRC5_RESID);
      end
      DATA: begin
        w_len_ok  = (w_len >= CNT_W'(16)) && (w_len <= CNT_W'(PAY_W+16)) &&
                    (w_len[2:0] == 3'd0);
        w_crc_bad = (w_crc16 != CRC16_RESID);
      end
      default: ;
    endcase
  end

  // CHECK stage: results captured here and frozen through DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_status    <= PROCESSING;
      r_rc_pid    <= '0;
      r_rc_class  <= HSHAKE;
      r_rc_data   <= '0;
      r_rc_nbytes <= '0;
      r_rc_addr   <= '0;
      r_rc_endp   <= '0;
      r_pid_err   <= 1'b0;
      r_crc_err   <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_status <= ((r_state == S_DONE) && !pkt_rec) ? RECEIVED : PROCESSING;
      if (r_state == S_CHECK) begin
        r_rc_pid    <= r_pid;
        r_rc_class  <= w_cls;
        r_rc_data   <= r_data;
        r_rc_nbytes <= (w_cls == DATA && w_len_ok) ? ((w_len - CNT_W'(16)) >> 3) : '0;
        r_rc_addr   <= (w_cls == TOKEN && w_len_ok) ? r_dly[15:9] : '0;
        r_rc_endp   <= (w_cls == TOKEN && w_len_ok) ? r_dly[8:5]  : '0;
        r_pid_err   <= (w_cls == INVALID);
        r_len_err   <= !w_len_ok;
        r_crc_err   <= w_len_ok && w_crc_bad;
      end
    end
  end

  assign pkt_status = r_status;
  assign rc_pid     = r_rc_pid;
  assign rc_class   = r_rc_class;
  assign rc_data    = r_rc_data;
  assign rc_nbytes  = r_rc_nbytes;
  assign rc_addr    = r_rc_addr;
  assign rc_endp    = r_rc_endp;
  assign PID_error  = r_pid_err;
  assign CRC_error  = r_crc_err;
  assign len_error  = r_len_err;

endmodule

// File: doc/rc_pkt_decoder.md
Name: rc_pkt_decoder

Overview:
- Generalised receive-side packet decoder for the USB receive path, replacing the fixed PID-check plus 64-bit CRC16 receiver pair.
- Accepts the unstuffed serial bit stream from the bit unstuffer and validates the PID.
- Classifies the packet as token, data or handshake, then checks CRC5 or CRC16 according to that class.
- Captures a variable-length payload (0..MAX_BYTES bytes) and holds the result until the protocol FSM acknowledges it.

Parameters:
- MAX_BYTES, 8, maximum data payload in bytes. Must be at least 1.
- CNT_W, $clog2(MAX_BYTES*8+25), width of the bit counter. This is derived; do not override it.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- start_decode  in  1  first packet bit is present on s_in this cycle
- end_decode  in  1  packet finished; s_in is not sampled this cycle
- s_in  in  1  unstuffed serial bit
- pkt_rec  in  1  consumer acknowledge, one-cycle pulse
- pkt_status  out  1  0 = PROCESSING, 1 = RECEIVED
- rc_pid  out  8  captured PID byte
- rc_class  out  2  pid_class_t: HSHAKE, TOKEN, DATA, INVALID
- rc_data  out  MAX_BYTES*8  payload, right-justified; unused upper bits are 0
- rc_nbytes  out  CNT_W  payload byte count
- rc_addr  out  7  token address
- rc_endp  out  4  token endpoint
- PID_error  out  1  PID check failed
- CRC_error  out  1  CRC residual mismatch
- len_error  out  1  bit count illegal for the packet class

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, pkt_status=0. All data outputs and error flags are 0; internal counter and shift registers are cleared. Reset wins over every other input in any state, including mid-packet.
- Bit order: bits are shifted in MSB-first, so the first received bit ends at the MSB of its field. PID = first 8 bits.
- PID is valid iff rc_pid[7:4] == ~rc_pid[3:0] and it matches a code in the package. Otherwise PID_error=1 and class=INVALID.
- FSM states: IDLE, RECV, CHECK, DONE.
  - IDLE: on start_decode, go to RECV. s_in is sampled that same cycle as bit 0 and the counter is set to 1.
  - RECV: sample s_in every cycle while end_decode=0. On end_decode, go to CHECK with no sample taken.
  - CHECK: one cycle to evaluate the class, length and CRC, then register the outputs. Next state is DONE.
  - DONE: pkt_status=1 and outputs are held stable. On pkt_rec, go to IDLE with pkt_status=0 the next cycle; the data outputs keep their values until the next CHECK. start_decode is ignored in DONE.
- Latency: end_decode sampled at edge k gives pkt_status=1 after edge k+2.
- Data path:
  - After the PID, bits pass through a 16-bit delay line.
  - Bits leaving the delay line shift into the payload register. Once MAX_BYTES*8 bits have been shifted in, further payload shifts are suppressed.
  - At CHECK, the delay line holds the trailing CRC field.
- CRC rules:
  - CRC16: polynomial x^16+x^15+x^2+1, initialised to all ones, run over every bit after the PID including the CRC field. Pass iff the residual equals 16'h800D.
  - CRC5: polynomial x^5+x^2+1, initialised to all ones, same scope. Pass iff the residual equals 5'b01100.
  - Both LFSRs run in parallel; the class selects which result is used.
- Length rules, with L = bits after the PID:
  - HSHAKE: L must equal 0.
  - TOKEN: L must equal 16. rc_addr = first 7 bits, rc_endp = next 4.
  - DATA: L must satisfy 16 ≤ L ≤ MAX_BYTES*8+16 and L mod 8 = 0. rc_nbytes = (L-16)/8.
  - Violation sets len_error=1, and CRC_error is forced to 0.
- Counter saturates at its maximum, so overlong packets never wrap.
- end_decode with fewer than 8 bits: PID_error=1 and len_error=1.
- Simultaneous start_decode and end_decode in IDLE: treated as a zero-length packet, with PID_error=1 and len_error=1.
- pkt_rec outside DONE is ignored.

Decomposition:
- Package rc_pkt_pkg holds:
  - `PROCESSING / RECEIVED status constants;
  - pid_class_t;
  - captured PID codes: OUT=8'b10000111, IN=8'b10010110, SETUP=8'b10110100, DATA0=8'b11000011, DATA1=8'b11010010, ACK=8'b01001011, NAK=8'b01011010, STALL=8'b01111000;
  - CRC polynomial and residual constants.
- One sub-module: rc_crc_lfsr, parametrised in width, polynomial and initial value, instantiated once for CRC5 and once for CRC16.
- The FSM and datapath stay in the top module.

Test Plan:
- ACK byte 01001011, then end_decode → class=HSHAKE, all errors 0, rc_nbytes=0, pkt_status=1 two cycles after end. Pulse pkt_rec → pkt_status=0 the next cycle.
- DATA0 (11000011) + 64-bit payload 1111011101111101101101010111101101111101010111010111111101010011 + correct CRC16 from the model → rc_data equals the payload, rc_nbytes=8, CRC_error=0.
- OUT token with addr=7'h3A, endp=4'h1 and correct CRC5 → rc_addr=3A, rc_endp=1, no errors. Flip one CRC bit → CRC_error=1.
- DATA1 with 3-byte payload 0xA5,0x0F,0x81 → rc_data=24'hA50F81 with upper bits 0, rc_nbytes=3. Repeat with 9 bytes → len_error=1, CRC_error=0.
- PID 11000000 → PID_error=1, class=INVALID. 5-bit packet → PID_error=1, len_error=1.
- rst_n=0 for one cycle mid-payload → IDLE, all outputs 0. A following clean ACK decodes correctly.
